// File: rtl/keypad_scanner.sv
// Matrix keypad front end: column scan, row synchroniser, per-frame
// single-key detection, press/release debounce and a valid/ack command port.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] H,
  output logic [3:0] V,
  output logic       valid,
  output logic [3:0] cmd,
  input  logic       ack
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       h_meta, h_sync;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  // Lows seen so far this frame: 0, 1, or 2 meaning "more than one".
  logic [1:0]       acc_n_q;
  logic [3:0]       acc_code_q;

  logic [3:0] low;
  logic       sample, frame_end, sample_zero, sample_one;
  logic [1:0] sample_row;
  logic [1:0] tot_n;
  logic [3:0] tot_code;
  logic       frame_key, frame_none;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] relcnt_q, relcnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             valid_d;
  logic [3:0]       cmd_d;

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      h_meta <= '1;
      h_sync <= '1;
    end else begin
      h_meta <= H;
      h_sync <= h_meta;
    end
  end

  // Only the active column is pulled low.
  always_comb begin
    V = ~(4'b0001 << col_q);
  end

  // Classify the current sample and fold it into the running frame result.
  always_comb begin
    low         = ~h_sync;
    sample      = (div_q == DIV_LAST);
    frame_end   = sample && (col_q == 2'd3);
    sample_zero = (low == 4'd0);
    sample_one  = !sample_zero && ((low & (low - 4'd1)) == 4'd0);
    sample_row  = 2'd0;
    case (low)
      4'b0010: sample_row = 2'd1;
      4'b0100: sample_row = 2'd2;
      4'b1000: sample_row = 2'd3;
      default: sample_row = 2'd0;
    endcase
    if (sample_zero)                        tot_n = acc_n_q;
    else if (sample_one && acc_n_q == 2'd0) tot_n = 2'd1;
    else                                    tot_n = 2'd2;
    tot_code   = (acc_n_q == 2'd0) ? {sample_row, col_q} : acc_code_q;
    frame_key  = frame_end && (tot_n == 2'd1);
    frame_none = frame_end && (tot_n == 2'd0);
  end

  // Dwell counter, column index and frame accumulator; runs in every state.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      div_q      <= '0;
      col_q      <= '0;
      acc_n_q    <= '0;
      acc_code_q <= '0;
    end else if (sample) begin
      div_q      <= '0;
      col_q      <= col_q + 2'd1;
      acc_n_q    <= frame_end ? 2'd0 : tot_n;
      acc_code_q <= tot_code;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Debounce / handshake state register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      relcnt_q <= '0;
      cand_q   <= '0;
      valid    <= 1'b0;
      cmd      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      relcnt_q <= relcnt_d;
      cand_q   <= cand_d;
      valid    <= valid_d;
      cmd      <= cmd_d;
    end
  end

  // Next-state: press debounce in IDLE, hold in PRESENT, release debounce.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relcnt_d = relcnt_q;
    cand_d   = cand_q;
    valid_d  = valid;
    cmd_d    = cmd;
    case (state_q)
      IDLE: begin
        // The frame that completes the count never coincides with issue,
        // so issuing takes priority over frame bookkeeping.
        if (cnt_q == DEB_MAX) begin
          valid_d = 1'b1;
          cmd_d   = cand_q;
          state_d = PRESENT;
        end else if (frame_key) begin
          if (tot_code == cand_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cand_d = tot_code;
            cnt_d  = CNT_W'(1);
          end
        end else if (frame_end) begin
          cnt_d = '0;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_d  = 1'b0;
          relcnt_d = '0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (frame_none) begin
          if (relcnt_q == DEB_LAST) begin
            state_d  = IDLE;
            cnt_d    = '0;
            cand_d   = '0;
            relcnt_d = '0;
          end else begin
            relcnt_d = relcnt_q + CNT_W'(1);
          end
        end else if (frame_end) begin
          relcnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, directed scenarios with
// hand-computed timing, then randomized presses/acks/resets, all checked
// every cycle against a frame-level behavioural model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 2;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] H;
  logic [3:0] V;
  logic       valid;
  logic [3:0] cmd;
  logic       ack;
  logic [15:0] keys;   // keys[row*4+col] = pressed

  int checks   = 0;
  int failures = 0;
  int scen     = 0;
  int ecnt     = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .H     (H),
    .V     (V),
    .valid (valid),
    .cmd   (cmd),
    .ack   (ack)
  );

  always #5 Clock = ~Clock;

  // Key matrix: a pressed key shorts its row to its column when driven low.
  always_comb begin
    H = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !V[c]) H[r] = 1'b0;
  end

  // Edges since last reset release, for stimulus timing.
  always @(posedge Clock) ecnt <= Reset ? ecnt + 1 : 0;

  // ---------------- behavioural model ----------------
  int         m_edges, last_edge;
  logic [3:0] m_hd1, m_hd2;
  int         fr_lows;
  logic [3:0] fr_code;
  int         m_phase;          // 0 waiting for press, 1 holding command, 2 waiting for release
  int         m_streak, m_cand, m_relc;
  logic       m_valid;
  logic [3:0] m_cmd, m_v;
  logic       lat_rst = 1'b0, lat_ack = 1'b0;
  logic [3:0] lat_h = 4'hF;

  task automatic model_step(input logic rst, input logic a, input logic [3:0] h);
    logic [3:0] hs, lows, one4;
    int col, res, nl;
    bit fdone;
    one4 = 4'b0001;
    if (!rst) begin
      m_edges = 0; last_edge = -1;
      m_hd1 = 4'hF; m_hd2 = 4'hF;
      fr_lows = 0; fr_code = 4'd0;
      m_phase = 0; m_streak = 0; m_cand = 0; m_relc = 0;
      m_valid = 1'b0; m_cmd = 4'd0;
    end else begin
      hs = m_hd2; m_hd2 = m_hd1; m_hd1 = h;   // two-cycle synchroniser delay
      fdone = 0; res = 16;
      if (m_edges % SD == SD - 1) begin
        col  = (m_edges / SD) % 4;
        lows = ~hs;
        nl   = $countones(lows);
        fr_lows += nl;
        if (nl == 1)
          for (int r = 0; r < 4; r++) if (lows[r]) fr_code = 4'(r*4 + col);
        if (col == 3) begin
          fdone = 1;
          if (fr_lows == 0)      res = 16;           // NONE
          else if (fr_lows == 1) res = int'(fr_code); // KEY
          else                   res = 17;           // MULTI
          fr_lows = 0;
        end
      end
      case (m_phase)
        0: begin
          if (m_streak == DB) begin
            m_valid = 1'b1; m_cmd = 4'(m_cand); m_phase = 1;
          end else if (fdone) begin
            if (res < 16) begin
              if (res == m_cand) m_streak++;
              else begin m_cand = res; m_streak = 1; end
            end else m_streak = 0;
          end
        end
        1: if (a) begin m_valid = 1'b0; m_relc = 0; m_phase = 2; end
        default: begin
          if (fdone) begin
            if (res == 16) begin
              m_relc++;
              if (m_relc == DB) begin m_phase = 0; m_streak = 0; m_cand = 0; m_relc = 0; end
            end else m_relc = 0;
          end
        end
      endcase
      last_edge = m_edges;
      m_edges++;
    end
    m_v = ~(one4 << ((m_edges / SD) % 4));
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (scen %0d edge %0d)", nm, act, exp, scen, last_edge);
    end
  endtask

  // Single compare process: advance the model by the edge just taken,
  // check DUT against it and against literal timing points, latch inputs.
  always @(negedge Clock) begin
    model_step(lat_rst, lat_ack, lat_h);
    chk("V", V, m_v);
    chk("valid", {3'b0, valid}, {3'b0, m_valid});
    chk("cmd", cmd, m_cmd);
    case (scen)
      1: begin
        if (last_edge == -1) begin
          chk("rst_V", V, 4'b1110); chk("rst_valid", {3'b0, valid}, 4'd0); chk("rst_cmd", cmd, 4'd0);
        end
        if (last_edge == 3)  chk("V_step1", V, 4'b1101);
        if (last_edge == 7)  chk("V_step2", V, 4'b1011);
        if (last_edge == 11) chk("V_step3", V, 4'b0111);
        if (last_edge == 15) chk("V_wrap", V, 4'b1110);
        if (last_edge == 31) chk("press_pre", {3'b0, valid}, 4'd0);
        if (last_edge == 32) begin
          chk("press_valid", {3'b0, valid}, 4'd1); chk("press_cmd", cmd, 4'd6);
          chk("model_valid", {3'b0, m_valid}, 4'd1); chk("model_cmd", m_cmd, 4'd6);
        end
        if (last_edge == 40)  chk("hold_valid", {3'b0, valid}, 4'd1);
        if (last_edge == 41)  chk("ack_drop", {3'b0, valid}, 4'd0);
        if (last_edge == 100) chk("no_repeat", {3'b0, valid}, 4'd0);
      end
      2: begin
        if (last_edge == 175) chk("repress_pre", {3'b0, valid}, 4'd0);
        if (last_edge == 176) begin chk("repress_valid", {3'b0, valid}, 4'd1); chk("repress_cmd", cmd, 4'd12); end
        if (last_edge == 350 || last_edge == 367) chk("bounce_none", {3'b0, valid}, 4'd0);
        if (last_edge == 368) chk("settle_valid", {3'b0, valid}, 4'd1);
        if (last_edge == 371) chk("settle_ack", {3'b0, valid}, 4'd0);
      end
      3: begin
        if (last_edge == 32 || last_edge == 79) begin
          chk("early_valid", {3'b0, valid}, 4'd1); chk("early_cmd", cmd, 4'd6);
        end
        if (last_edge == 81)  chk("early_ack", {3'b0, valid}, 4'd0);
        if (last_edge == 150) chk("early_noextra", {3'b0, valid}, 4'd0);
      end
      4: begin
        if (last_edge == 99 || last_edge == 143) chk("ghost_none", {3'b0, valid}, 4'd0);
        if (last_edge == 144) begin chk("ghost_valid", {3'b0, valid}, 4'd1); chk("ghost_cmd", cmd, 4'd9); end
      end
      5: begin
        if (last_edge == -1) chk("midrst_valid", {3'b0, valid}, 4'd0);
        if (last_edge == 31) chk("midrst_pre", {3'b0, valid}, 4'd0);
        if (last_edge == 32) begin chk("midrst_valid2", {3'b0, valid}, 4'd1); chk("midrst_cmd", cmd, 4'd9); end
      end
      default: ;
    endcase
    lat_rst = Reset;
    lat_ack = ack;
    lat_h   = H;
  end

  // ---------------- stimulus ----------------
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge Clock); #2;
      guard++;
    end while (ecnt != n + 1 && guard < 2000);
    if (guard >= 2000) begin
      $display("FAIL wait_edge: edge %0d not reached, at %0d", n, ecnt);
      $fatal(1);
    end
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b0;
    repeat (n) @(posedge Clock);
    #2 Reset = 1'b1;
  endtask

  initial begin
    logic [15:0] one16;
    one16 = 16'd1;
    // Reset check and single press (row1/col2)
    scen = 1; ack = 1'b0; keys = 16'd0; keys[6] = 1'b1; Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b1;
    wait_edge(40);  ack = 1'b1;
    // Release, repress row3/col0, bounce, settle
    wait_edge(100); scen = 2; keys = 16'd0;
    wait_edge(130); keys[12] = 1'b1; ack = 1'b0;
    wait_edge(180); ack = 1'b1;
    wait_edge(185); keys = 16'd0; ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_edge(239 + 16*k);
      keys = (k % 2 == 0) ? (one16 << 12) : 16'd0;
    end
    wait_edge(335); keys = one16 << 12;
    wait_edge(370); ack = 1'b1;
    // Early release without ack
    wait_edge(400); scen = 3; keys = one16 << 6; ack = 1'b0;
    do_reset(1);
    wait_edge(35);  keys = 16'd0;
    wait_edge(80);  ack = 1'b1;
    // Ghosting: row0/col0 + row2/col1, then drop row0/col0
    wait_edge(160); scen = 4; keys = (one16 << 0) | (one16 << 9); ack = 1'b0;
    do_reset(1);
    wait_edge(100); keys = one16 << 9;
    // Reset while valid is high, key still held
    wait_edge(150); scen = 5;
    do_reset(1);
    wait_edge(40);  ack = 1'b1;
    wait_edge(60);  ack = 1'b0;
    // Randomized presses, acks and occasional resets
    scen = 6;
    for (int s = 0; s < 250; s++) begin
      int unsigned r, len;
      r = $urandom_range(0, 9);
      if (r < 3)      keys = 16'd0;
      else if (r < 8) keys = one16 << $urandom_range(0, 15);
      else            keys = (one16 << $urandom_range(0, 15)) | (one16 << $urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) do_reset(1);
      len = $urandom_range(4, 110);
      for (int unsigned i = 0; i < len; i++) begin
        ack = ($urandom_range(0, 5) == 0);
        @(posedge Clock); #2;
      end
    end
    repeat (3) @(posedge Clock);
    @(negedge Clock); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix-keypad front end that produces the key command stream consumed by the CPU's input handshake (cmd/ack).
- Drives the 4 column lines V one at a time and samples the 4 row lines H through a synchroniser.
- Debounces the samples and encodes a single pressed key into a 4-bit code.
- Presents the code with a valid/ack handshake. Exactly one command is issued per press; there is no autorepeat.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell), must be ≥2.
- DEBOUNCE, 4: consecutive identical frames required for press and for release, must be ≥1.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- H      in  4  row inputs, active-low (pulled up); asynchronous to Clock.
- V      out 4  column drive, active-low, exactly one bit low at all times.
- valid  out 1  cmd holds a new key code.
- cmd    out 4  key code = {row[1:0], col[1:0]}, i.e. row*4+col.
- ack    in  1  consumer accepts cmd; meaningful only while valid=1.

Behaviour:
- Reset (Reset=0 at an edge):
  - V=4'b1110, valid=0, cmd=0.
  - Dwell counter and column index cleared to 0; debounce counters 0; state IDLE.
  - Synchroniser flops loaded with 4'b1111.
  - Reset mid-handshake drops valid on the next edge; the pending key is discarded.
- Synchroniser: H passes through 2 flops (Hs). H must be stable for ≥2 cycles before the sample edge to be seen.
- Scan timing:
  - Dwell counter runs 0..SCAN_DIV-1.
  - On the cycle where the count is SCAN_DIV-1, Hs is sampled for the current column, the column index advances (3 wraps to 0), and V updates on the same edge.
  - Frame = 4 columns = 4*SCAN_DIV cycles. The frame ends on the column-3 sample.
  - Scanning never stops, in any state.
- Frame result:
  - KEY(code) when exactly one Hs bit was low in exactly one column over the frame.
  - NONE when no Hs bit was low anywhere.
  - MULTI otherwise. MULTI (ghosting) is treated as not-a-key and not-released.
- States:
  - IDLE:
    - KEY(c) with c==candidate increments cnt; any other KEY loads candidate=c, cnt=1; NONE/MULTI clears cnt=0.
    - When cnt reaches DEBOUNCE: on the edge after the frame end, cmd<=candidate, valid<=1, go PRESENT.
  - PRESENT:
    - valid=1; cmd is frozen and ignores further frames or key release.
    - On an edge with ack=1: valid<=0, relcnt<=0, go RELEASE.
    - No timeout.
  - RELEASE:
    - Each NONE frame increments relcnt; KEY or MULTI clears relcnt.
    - relcnt reaching DEBOUNCE: go IDLE with cnt=0, candidate=0.
    - Counting starts with the first frame ending after entry; a frame in progress at entry still counts.
- Handshake:
  - ack while valid=0 is ignored.
  - ack held high continuously consumes exactly one command per press.
  - valid never rises in the cycle it falls.
- Latency: a stable key present from a frame start gives valid high 1 cycle after the end of the DEBOUNCE-th frame.
- Counter widths: sized from the parameters (clog2); no overflow, since counters saturate at DEBOUNCE.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE=2, cycle 0 = first edge with Reset=1.
- Reset check: Reset=0 for 3 cycles, H=4'hF → V=4'b1110, valid=0, cmd=0. V then steps 1101, 1011, 0111 every 4 cycles and wraps.
- Single press: key row1/col2 held from cycle 0 (H[1]=0 whenever V[2]=0).
  - valid rises at cycle 32 with cmd=4'd6.
  - ack=1 at cycle 40 → valid=0 at cycle 41.
  - Key still held → no second valid.
- Release and repress:
  - After the accepted press, release the key → IDLE after 2 NONE frames.
  - Press row3/col0 → valid with cmd=4'd12 after 2 frames.
  - Key bouncing (alternating per frame) before it settles → no valid.
- Early release: release the key at cycle 35 without ack.
  - valid stays 1 and cmd stays 6 until ack.
  - After ack, return to IDLE after 2 NONE frames with no extra command.
- Ghosting: row0/col0 and row2/col1 both held → MULTI every frame, valid never asserts.
  - Releasing one key leaves the other, and valid then asserts with that key's code.
- Reset mid-PRESENT: Reset=0 for one cycle while valid=1 → valid=0 on the next edge.
  - Key still held → a fresh command appears after 2 full frames.
